// File: rtl/cond_flag_unit.sv
// NZCV flag producer: architectural flags register, condition evaluation,
// condition-gated control outputs, one-deep save/restore shadow and squash counter.
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Stall,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlagsE,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             FlagsSave,
  input  logic             FlagsRestore,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic             CondExE,
  output logic             PCSrcGated,
  output logic             RegWriteGated,
  output logic             MemWriteGated,
  output logic [CNT_W-1:0] SquashCount
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic [3:0]       flags_q, flags_d;
  logic [3:0]       saved_q, saved_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             cond_ex;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             advance;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign advance = ~Stall;

  // Condition evaluated against the registered flags, never the in-flight ALU flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond_ex = 1'b0;
    unique case (cond_e'(CondE))
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = ~flag_z & flag_c;
      COND_LS: cond_ex = flag_z | ~flag_c;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  assign CondExE       = cond_ex;
  assign PCSrcGated    = PCSrcE    & cond_ex & ValidE;
  assign RegWriteGated = RegWriteE & cond_ex & ValidE;
  assign MemWriteGated = MemWriteE & cond_ex & ValidE;

  always_comb begin
    flags_d  = flags_q;
    saved_d  = saved_q;
    squash_d = squash_q;

    if (advance && ValidE && cond_ex) begin
      if (FlagWriteE[1]) flags_d[3:2] = ALUFlagsE[3:2];
      if (FlagWriteE[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
    // Restore wins over a same-cycle ALU write; both sources are pre-edge values,
    // so save+restore together swaps the two registers.
    if (advance && FlagsRestore) flags_d = saved_q;
    if (advance && FlagsSave)    saved_d = flags_q;

    if (advance && ValidE && !cond_ex && (squash_q != {CNT_W{1'b1}}))
      squash_d = squash_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RESETn) begin
      flags_q  <= '0;
      saved_q  <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      saved_q  <= saved_d;
      squash_q <= squash_d;
    end
  end

  assign Flags       = flags_q;
  assign SavedFlags  = saved_q;
  assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: a default-width instance and a CNT_W=2
// instance share all stimulus; expected values are hand-computed constants.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, valid;
  logic [3:0] cond;
  logic [1:0] fw;
  logic [3:0] alu;
  logic       pcsrc, regw, memw, fsave, frest;

  logic [3:0]  flags_a, saved_a, flags_b, saved_b;
  logic        condex_a, pcg_a, rwg_a, mwg_a;
  logic        condex_b, pcg_b, rwg_b, mwg_b;
  logic [15:0] sq_a;
  logic [1:0]  sq_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_flag_unit dut_a (
    .CLK(clk), .RESETn(rst_n), .Stall(stall), .ValidE(valid), .CondE(cond),
    .FlagWriteE(fw), .ALUFlagsE(alu), .PCSrcE(pcsrc), .RegWriteE(regw),
    .MemWriteE(memw), .FlagsSave(fsave), .FlagsRestore(frest),
    .Flags(flags_a), .SavedFlags(saved_a), .CondExE(condex_a),
    .PCSrcGated(pcg_a), .RegWriteGated(rwg_a), .MemWriteGated(mwg_a),
    .SquashCount(sq_a)
  );

  cond_flag_unit #(.CNT_W(2)) dut_b (
    .CLK(clk), .RESETn(rst_n), .Stall(stall), .ValidE(valid), .CondE(cond),
    .FlagWriteE(fw), .ALUFlagsE(alu), .PCSrcE(pcsrc), .RegWriteE(regw),
    .MemWriteE(memw), .FlagsSave(fsave), .FlagsRestore(frest),
    .Flags(flags_b), .SavedFlags(saved_b), .CondExE(condex_b),
    .PCSrcGated(pcg_b), .RegWriteGated(rwg_b), .MemWriteGated(mwg_b),
    .SquashCount(sq_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Registered state of both instances against one expectation.
  task automatic check_regs(input string tag, input logic [3:0] f, input logic [3:0] s,
                            input logic [15:0] sq, input logic [1:0] sq2);
    check({tag, ".flags"},  16'(flags_a), 16'(f));
    check({tag, ".saved"},  16'(saved_a), 16'(s));
    check({tag, ".squash"}, sq_a, sq);
    check({tag, ".flags2"}, 16'(flags_b), 16'(f));
    check({tag, ".saved2"}, 16'(saved_b), 16'(s));
    check({tag, ".squash2"}, 16'(sq_b), 16'(sq2));
  endtask

  task automatic check_comb(input string tag, input logic ce, input logic pc,
                            input logic rw, input logic mw);
    #1;
    check({tag, ".condex"}, 16'(condex_a), 16'(ce));
    check({tag, ".gated"},  16'({pcg_a, rwg_a, mwg_a}), 16'({pc, rw, mw}));
    check({tag, ".gated2"}, 16'({condex_b, pcg_b, rwg_b, mwg_b}), 16'({ce, pc, rw, mw}));
  endtask

  // Inputs change 1 time unit after the rising edge; registers are sampled then.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] v);
    valid = 1'b1; cond = 4'b1110; fw = 2'b11; alu = v;
    step();
    valid = 1'b0; fw = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; valid = 1'b0; cond = 4'b0000; fw = 2'b00;
    alu = 4'b0000; pcsrc = 1'b0; regw = 1'b0; memw = 1'b0; fsave = 1'b0; frest = 1'b0;

    // Reset
    step();
    check_regs("reset", 4'b0000, 4'b0000, 16'd0, 2'd0);
    rst_n = 1'b1;
    valid = 1'b1; cond = 4'b0001;
    check_comb("reset_ne", 1'b1, 1'b0, 1'b0, 1'b0);

    // CMP then Bcc
    cond = 4'b1110; fw = 2'b11; alu = 4'b0100;
    step();
    check_regs("cmp", 4'b0100, 4'b0000, 16'd0, 2'd0);
    fw = 2'b00; cond = 4'b0000; pcsrc = 1'b1; regw = 1'b1;
    check_comb("beq_taken", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_regs("beq_nosq", 4'b0100, 4'b0000, 16'd0, 2'd0);
    cond = 4'b0001;
    check_comb("bne_fail", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("bne_sq", 4'b0100, 4'b0000, 16'd1, 2'd1);
    valid = 1'b0; cond = 4'b1110; memw = 1'b1;
    check_comb("invalid", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("invalid_nosq", 4'b0100, 4'b0000, 16'd1, 2'd1);
    pcsrc = 1'b0; regw = 1'b0; memw = 1'b0;

    // Partial flag write
    write_flags(4'b1010);
    check_regs("pw_setup", 4'b1010, 4'b0000, 16'd1, 2'd1);
    valid = 1'b1; cond = 4'b1110; fw = 2'b10; alu = 4'b0101;
    step();
    check_regs("pw_nz", 4'b0110, 4'b0000, 16'd1, 2'd1);
    fw = 2'b01; alu = 4'b1001;
    step();
    check_regs("pw_cv", 4'b0101, 4'b0000, 16'd1, 2'd1);
    valid = 1'b0; fw = 2'b00;

    // Save / restore
    write_flags(4'b1001);
    fsave = 1'b1;
    step();
    fsave = 1'b0;
    check_regs("save", 4'b1001, 4'b1001, 16'd1, 2'd1);
    write_flags(4'b0000);
    check_regs("alu_clr", 4'b0000, 4'b1001, 16'd1, 2'd1);
    valid = 1'b1; cond = 4'b1110; fw = 2'b11; alu = 4'b1111; frest = 1'b1;
    step();
    frest = 1'b0; valid = 1'b0; fw = 2'b00;
    check_regs("restore_wins", 4'b1001, 4'b1001, 16'd1, 2'd1);
    write_flags(4'b1100);
    fsave = 1'b1;
    step();
    fsave = 1'b0;
    write_flags(4'b0011);
    check_regs("swap_setup", 4'b0011, 4'b1100, 16'd1, 2'd1);
    fsave = 1'b1; frest = 1'b1;
    step();
    fsave = 1'b0; frest = 1'b0;
    check_regs("swap", 4'b1100, 4'b0011, 16'd1, 2'd1);

    // Compound conditions with N=1 Z=1 C=0 V=0
    valid = 1'b1; pcsrc = 1'b1;
    cond = 4'b1000; check_comb("hi", 1'b0, 1'b0, 1'b0, 1'b0);
    cond = 4'b1001; check_comb("ls", 1'b1, 1'b1, 1'b0, 1'b0);
    cond = 4'b1010; check_comb("ge", 1'b0, 1'b0, 1'b0, 1'b0);
    cond = 4'b1011; check_comb("lt", 1'b1, 1'b1, 1'b0, 1'b0);
    cond = 4'b1100; check_comb("gt", 1'b0, 1'b0, 1'b0, 1'b0);
    cond = 4'b1101; check_comb("le", 1'b1, 1'b1, 1'b0, 1'b0);
    cond = 4'b0100; check_comb("mi", 1'b1, 1'b1, 1'b0, 1'b0);
    cond = 4'b0110; check_comb("vs", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall holds every register while gated outputs still track
    stall = 1'b1;
    cond = 4'b1110; fw = 2'b11; alu = 4'b0000; fsave = 1'b1;
    check_comb("stall_al", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_regs("stall_write", 4'b1100, 4'b0011, 16'd1, 2'd1);
    cond = 4'b0010; frest = 1'b1;
    check_comb("stall_fail", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("stall_squash", 4'b1100, 4'b0011, 16'd1, 2'd1);
    stall = 1'b0; fsave = 1'b0; frest = 1'b0; fw = 2'b00;

    // Mid-stream reset: flag-writing instruction in the same cycle is dropped
    rst_n = 1'b0; cond = 4'b1110; fw = 2'b11; alu = 4'b1111; fsave = 1'b1;
    step();
    rst_n = 1'b1; fsave = 1'b0;
    check_regs("midreset", 4'b0000, 4'b0000, 16'd0, 2'd0);

    // Reserved condition: squash counter saturates on the narrow instance
    valid = 1'b1; cond = 4'b1111; fw = 2'b11; alu = 4'b1111;
    pcsrc = 1'b1; regw = 1'b1; memw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check_comb("nv", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check_regs("nv_sat", 4'b0000, 4'b0000, 16'(i), (i > 3) ? 2'd3 : 2'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
